// File: rtl/adc_seq_ctrl.sv
// adc_seq_ctrl
// Paces sample requests to an ADC, runs the four-phase req/rdy handshake and
// hands each captured byte to the capture path as a one-cycle strobe with a
// running count. A missing rdy is caught by a timeout, flagged in err_to and
// recovered by putting the ADC back through its reset sequence.
//
// Ports
//   clk, reset         : system clock, asynchronous active-high reset
//   start, stop        : run control levels, sampled on clk
//   period             : idle cycles between samples, latched on start
//   rdy, dat           : ADC acknowledge and sample byte
//   req, rst           : ADC request and ADC reset (registered)
//   smp_dat, smp_vld   : captured byte and its one-cycle strobe
//   smp_cnt            : samples captured since start (wraps)
//   busy, err_to       : running indicator, sticky timeout flag
module adc_seq_ctrl #(
    parameter int PER_W      = 16,
    parameter int TIMEOUT    = 64,
    parameter int RST_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [PER_W-1:0] period,
    input  logic             rdy,
    input  logic [7:0]       dat,
    output logic             req,
    output logic             rst,
    output logic [7:0]       smp_dat,
    output logic             smp_vld,
    output logic [31:0]      smp_cnt,
    output logic             busy,
    output logic             err_to
);

    localparam int TO_W   = $clog2(TIMEOUT + 1);
    localparam int INIT_W = $clog2(RST_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_REQ   = 3'd3,
        ST_RDYLO = 3'd4
    } state_t;

    state_t             state_q,     state_d;
    logic [PER_W-1:0]   per_q,       per_d;
    logic [PER_W-1:0]   cnt_q,       cnt_d;
    logic [TO_W-1:0]    to_q,        to_d;
    logic [INIT_W-1:0]  init_q,      init_d;
    logic               stop_seen_q, stop_seen_d;
    logic [7:0]         smp_dat_q,   smp_dat_d;
    logic               smp_vld_q,   smp_vld_d;
    logic [31:0]        smp_cnt_q,   smp_cnt_d;
    logic               err_q,       err_d;
    logic               req_q,       req_d;
    logic               rst_q,       rst_d;
    logic               busy_q,      busy_d;

    // Next-state and next-output decode for the sequencer
    always_comb begin
        state_d     = state_q;
        per_d       = per_q;
        cnt_d       = cnt_q;
        to_d        = to_q;
        init_d      = init_q;
        stop_seen_d = stop_seen_q;
        smp_dat_d   = smp_dat_q;
        smp_vld_d   = 1'b0;
        smp_cnt_d   = smp_cnt_q;
        err_d       = err_q;

        case (state_q)
            ST_INIT: begin
                if (init_q == INIT_W'(RST_CYCLES - 1)) begin
                    init_d  = {INIT_W{1'b0}};
                    state_d = ST_IDLE;
                end else begin
                    init_d  = init_q + INIT_W'(1);
                end
            end
            ST_IDLE: begin
                // stop has priority over start
                if (start && !stop) begin
                    per_d     = period;
                    cnt_d     = period;
                    smp_cnt_d = 32'd0;
                    err_d     = 1'b0;
                    state_d   = ST_WAIT;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == {PER_W{1'b0}}) begin
                    to_d        = {TO_W{1'b0}};
                    stop_seen_d = 1'b0;
                    state_d     = ST_REQ;
                end else begin
                    cnt_d = cnt_q - PER_W'(1);
                end
            end
            ST_REQ: begin
                // stop never aborts a request; it only decides where RDYLO goes
                stop_seen_d = stop_seen_q | stop;
                if (rdy) begin
                    smp_dat_d = dat;
                    smp_vld_d = 1'b1;
                    smp_cnt_d = smp_cnt_q + 32'd1;
                    state_d   = ST_RDYLO;
                end else if (to_q == TO_W'(TIMEOUT - 1)) begin
                    err_d       = 1'b1;
                    init_d      = {INIT_W{1'b0}};
                    stop_seen_d = 1'b0;
                    state_d     = ST_INIT;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            ST_RDYLO: begin
                if (!rdy) begin
                    stop_seen_d = 1'b0;
                    if (stop_seen_q || stop) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = per_q;
                        state_d = ST_WAIT;
                    end
                end else begin
                    stop_seen_d = stop_seen_q | stop;
                end
            end
            default: begin
                init_d  = {INIT_W{1'b0}};
                state_d = ST_INIT;
            end
        endcase

        // Outputs are decoded from the next state so they register with it
        req_d  = (state_d == ST_REQ);
        rst_d  = (state_d == ST_INIT);
        busy_d = (state_d == ST_WAIT) || (state_d == ST_REQ) || (state_d == ST_RDYLO);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_INIT;
            per_q       <= {PER_W{1'b0}};
            cnt_q       <= {PER_W{1'b0}};
            to_q        <= {TO_W{1'b0}};
            init_q      <= {INIT_W{1'b0}};
            stop_seen_q <= 1'b0;
            smp_dat_q   <= 8'd0;
            smp_vld_q   <= 1'b0;
            smp_cnt_q   <= 32'd0;
            err_q       <= 1'b0;
            req_q       <= 1'b0;
            rst_q       <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            per_q       <= per_d;
            cnt_q       <= cnt_d;
            to_q        <= to_d;
            init_q      <= init_d;
            stop_seen_q <= stop_seen_d;
            smp_dat_q   <= smp_dat_d;
            smp_vld_q   <= smp_vld_d;
            smp_cnt_q   <= smp_cnt_d;
            err_q       <= err_d;
            req_q       <= req_d;
            rst_q       <= rst_d;
            busy_q      <= busy_d;
        end
    end

    assign req     = req_q;
    assign rst     = rst_q;
    assign smp_dat = smp_dat_q;
    assign smp_vld = smp_vld_q;
    assign smp_cnt = smp_cnt_q;
    assign busy    = busy_q;
    assign err_to  = err_q;

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Testbench for adc_seq_ctrl: randomized runs against an ADC model that
// pushes the expected capture into a scoreboard when it acknowledges; a
// monitor pops and compares on every smp_vld strobe.
module tb_adc_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset, start, stop, rdy;
    logic [15:0] period;
    logic [7:0]  dat, smp_dat;
    logic        req, rst, smp_vld, busy, err_to;
    logic [31:0] smp_cnt;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int got = 0;

    typedef struct {
        logic [7:0]  d;
        logic [31:0] c;
        int          gap;
    } exp_t;
    exp_t sb_q[$];

    // reference state shared by stimulus and the ADC model
    bit          adc_en = 1'b0;
    bit          first_flag = 1'b0;
    int          run_per = 0;
    logic [31:0] exp_cnt = 32'd0;

    adc_seq_ctrl #(.PER_W(16), .TIMEOUT(64), .RST_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .period(period),
        .rdy(rdy), .dat(dat), .req(req), .rst(rst), .smp_dat(smp_dat),
        .smp_vld(smp_vld), .smp_cnt(smp_cnt), .busy(busy), .err_to(err_to)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ADC model: acknowledges dly cycles into REQ, drops rdy one cycle after req falls
    initial begin : adc_model
        int ph, wt, dly;
        exp_t e;
        rdy = 1'b0; dat = 8'd0; ph = 0; wt = 0; dly = int'($urandom_range(0, 3));
        forever begin
            @(negedge clk);
            if (!adc_en || reset) begin
                rdy = 1'b0; ph = 0; wt = 0;
            end else begin
                case (ph)
                    0: if (req) begin
                        if (wt >= dly) begin
                            dat = 8'($urandom);
                            rdy = 1'b1;
                            exp_cnt = exp_cnt + 32'd1;
                            e.d = dat;
                            e.c = exp_cnt;
                            // WAIT per+1, REQ dly+1, RDYLO 2 between captures
                            e.gap = first_flag ? -1 : run_per + 4 + dly;
                            first_flag = 1'b0;
                            sb_q.push_back(e);
                            ph = 1;
                        end else begin
                            wt++;
                        end
                    end
                    1: if (!req) ph = 2;
                    default: begin
                        rdy = 1'b0; ph = 0; wt = 0; dly = int'($urandom_range(0, 3));
                    end
                endcase
            end
        end
    end

    // Monitor: pops the scoreboard on every strobe
    initial begin : monitor
        bit prev_vld;
        int last;
        exp_t e;
        prev_vld = 1'b0; last = 0;
        forever begin
            @(negedge clk);
            if (smp_vld === 1'b1) begin
                chk("vld_consecutive", prev_vld, 1'b0);
                chk("req_low_on_vld", req, 1'b0);
                if (sb_q.size() == 0) begin
                    chk("unexpected_vld", 1'b1, 1'b0);
                end else begin
                    e = sb_q.pop_front();
                    chk("smp_dat", smp_dat, e.d);
                    chk("smp_cnt", smp_cnt, e.c);
                    if (e.gap >= 0) chk("smp_spacing", cyc - last, e.gap);
                end
                last = cyc;
                got++;
            end
            prev_vld = (smp_vld === 1'b1);
        end
    end

    task automatic issue_start(input int per, input bit do_force);
        int lat;
        @(posedge clk); #1;
        period = per[15:0]; start = 1'b1; stop = 1'b0;
        run_per = per; exp_cnt = 32'd0; first_flag = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        period = 16'($urandom);   // must not affect the running interval
        lat = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("start_busy", busy, 1'b1);
                chk("start_err_clear", err_to, 1'b0);
                chk("start_cnt_clear", smp_cnt, 32'd0);
            end
            if (do_force && i == 2) begin
                force dut.smp_cnt_q = 32'hFFFF_FFFF;
                exp_cnt = 32'hFFFF_FFFF;
            end
            if (do_force && i == 3) release dut.smp_cnt_q;
            if (req) break;
            lat++;
        end
        chk("first_req_latency", lat, per + 1);
    endtask

    task automatic wait_samples(input int target);
        for (int i = 0; i < 800; i++) begin
            if (got >= target) break;
            @(negedge clk);
        end
        chk("samples_arrived", got >= target, 1'b1);
    endtask

    task automatic check_goes_idle();
        int bad;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("idle_after_stop", busy, 1'b0);
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (req || busy) bad++;
        end
        chk("stays_idle", bad, 0);
        chk("scoreboard_drained", sb_q.size(), 0);
    endtask

    task automatic stop_to_idle();
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        check_goes_idle();
    endtask

    task automatic count_rst(output int n, output int bad);
        n = 0; bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!rst) break;
            n++;
            if ({req, busy, smp_vld, smp_dat} != 11'd0) bad++;
        end
    endtask

    initial begin : main
        int n, bad, per, ns, g0;
        reset = 1'b1; start = 1'b0; stop = 1'b0; period = 16'd0;

        // reset held three cycles, then the INIT sequence
        repeat (3) begin
            @(negedge clk);
            chk("reset_outputs", {req, busy, smp_vld, err_to, smp_dat, smp_cnt}, 64'd0);
            chk("reset_rst_high", rst, 1'b1);
        end
        @(posedge clk); #1 reset = 1'b0;
        count_rst(n, bad);
        chk("init_rst_len", n, 4);
        chk("init_quiet", bad, 0);
        chk("init_cnt_err", {err_to, smp_cnt}, 33'd0);

        // paced runs, including period 5 and period 0
        adc_en = 1'b1;
        for (int r = 0; r < 6; r++) begin
            per = (r == 0) ? 5 : (r == 1) ? 0 : int'($urandom_range(0, 6));
            ns  = int'($urandom_range(1, 3));
            g0  = got;
            issue_start(per, 1'b0);
            wait_samples(g0 + ns);
            repeat ($urandom_range(0, 8)) @(posedge clk);
            stop_to_idle();
        end

        // stop pulsed while req is high: sample completes, then IDLE
        g0 = got;
        issue_start(3, 1'b0);
        stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        wait_samples(g0 + 1);
        check_goes_idle();
        chk("stop_hs_one_sample", got - g0, 1);

        // start and stop together in IDLE
        @(posedge clk); #1 start = 1'b1; stop = 1'b1;
        @(posedge clk); #1 start = 1'b0; stop = 1'b0;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (busy || req) bad++;
        end
        chk("start_stop_stay_idle", bad, 0);

        // timeout with rdy stuck low
        adc_en = 1'b0;
        issue_start(2, 1'b0);
        n = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!req) break;
            n++;
        end
        chk("timeout_req_len", n, 64);
        chk("timeout_err_to", err_to, 1'b1);
        chk("timeout_rst_rise", rst, 1'b1);
        n = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!rst) break;
            n++;
        end
        chk("timeout_rst_len", n, 4);
        chk("timeout_back_idle", {busy, err_to}, 2'b01);

        // new start clears err_to and restarts the count
        adc_en = 1'b1;
        g0 = got;
        issue_start(1, 1'b0);
        wait_samples(g0 + 2);
        stop_to_idle();

        // sample count wraps from all-ones to zero
        g0 = got;
        issue_start(20, 1'b1);
        wait_samples(g0 + 2);
        stop_to_idle();

        // reset asserted while req is high
        adc_en = 1'b0;
        g0 = got;
        issue_start(1, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("midreq_req_async", req, 1'b0);
        chk("midreq_rst_async", rst, 1'b1);
        @(posedge clk); @(posedge clk); #1 reset = 1'b0;
        count_rst(n, bad);
        chk("midreq_init_len", n, 4);
        chk("midreq_no_sample", got - g0, 0);

        // recovery run after the reset
        adc_en = 1'b1;
        g0 = got;
        issue_start(2, 1'b0);
        wait_samples(g0 + 2);
        stop_to_idle();

        chk("final_scoreboard_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
